ibuffer_parcel_queue: RTL and testbench

Circular queue of 16-bit instruction parcels between fetch and the ibuffer next-valid-instruction marker. It accepts one fetch block of up to PARCELS_PER_FETCH parcels per cycle and presents a WIDTH-parcel window at the queue head. The window's valid_vec and uncompressed_vec feed the marker directly. The decode-side consumer retires 0..WIDTH parcels per cycle from the head.

---
 rtl/ibuffer_parcel_queue_if.sv | 31 +++
 rtl/ibuffer_parcel_queue.sv | 125 ++++++++++++
 tb/tb_ibuffer_parcel_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ibuffer_parcel_queue_if.sv
// Fetch/decode-facing bundle for the parcel queue. The master side is the fetch
// unit plus the decode consumer; the slave side is the queue itself.
interface ibuffer_parcel_queue_if #(
  parameter int PARCELS_PER_FETCH = 8,
  parameter int DEPTH             = 32,
  parameter int WIDTH             = 8
);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(WIDTH + 1);

  logic                                flush;
  logic                                enq_valid;
  logic                                enq_ready;
  logic [PARCELS_PER_FETCH-1:0][15:0]  enq_parcels;
  logic [PARCELS_PER_FETCH-1:0]        enq_valid_vec;
  logic [WIDTH-1:0][15:0]              win_parcels;
  logic [WIDTH-1:0]                    win_valid_vec;
  logic [WIDTH-1:0]                    win_uncompressed_vec;
  logic [CW-1:0]                       deq_count;
  logic [OW-1:0]                       occupancy;

  modport master (
    output flush, enq_valid, enq_parcels, enq_valid_vec, deq_count,
    input  enq_ready, win_parcels, win_valid_vec, win_uncompressed_vec, occupancy
  );

  modport slave (
    input  flush, enq_valid, enq_parcels, enq_valid_vec, deq_count,
    output enq_ready, win_parcels, win_valid_vec, win_uncompressed_vec, occupancy
  );
endinterface

// File: rtl/ibuffer_parcel_queue.sv
// Circular queue of 16-bit instruction parcels: compacting fetch-block enqueue,
// combinational WIDTH-parcel head window, 0..WIDTH parcel dequeue per cycle.
module ibuffer_parcel_queue_lane #(
  parameter int IDX = 0,
  parameter int OW  = 6
) (
  input  logic [OW-1:0] occ_i,
  input  logic [15:0]   parcel_i,
  input  logic          unc_i,
  output logic [15:0]   parcel_o,
  output logic          valid_o,
  output logic          unc_o
);
  assign valid_o  = OW'(IDX) < occ_i;
  assign parcel_o = valid_o ? parcel_i : 16'h0000;
  assign unc_o    = valid_o & unc_i;
endmodule

module ibuffer_parcel_queue #(
  parameter int PARCELS_PER_FETCH = 8,
  parameter int DEPTH             = 32,
  parameter int WIDTH             = 8
) (
  input logic                   CLK,
  input logic                   rst,
  ibuffer_parcel_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int LW = $clog2(PARCELS_PER_FETCH);
  localparam int NW = $clog2(PARCELS_PER_FETCH + 1);

  logic [15:0]   mem_q [DEPTH];
  logic          unc_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;

  logic [NW-1:0]                n_cnt;
  logic [LW-1:0]                low;
  logic                         found;
  logic [PARCELS_PER_FETCH-1:0] mask_sh;
  logic                         mask_contig;
  logic                         enq_fire;
  logic [OW-1:0]                deq_ext, deq_eff;

  // enq_ready looks only at registered occupancy, never at same-cycle dequeue
  assign bus.enq_ready = ((OW+1)'(DEPTH) - {1'b0, occ_q}) >= (OW+1)'(PARCELS_PER_FETCH);
  assign enq_fire      = bus.enq_valid & bus.enq_ready & ~bus.flush & ~rst;
  assign bus.occupancy = occ_q;

  always_comb begin
    n_cnt = '0;
    low   = '0;
    found = 1'b0;
    for (int k = 0; k < PARCELS_PER_FETCH; k++) begin
      if (bus.enq_valid_vec[k]) begin
        n_cnt = n_cnt + NW'(1);
        if (!found) begin
          low   = LW'(k);
          found = 1'b1;
        end
      end
    end
  end

  assign mask_sh     = bus.enq_valid_vec >> low;
  assign mask_contig = (mask_sh & (mask_sh + 1'b1)) == '0;

  assign deq_ext = OW'(bus.deq_count);
  assign deq_eff = (deq_ext > occ_q) ? occ_q : deq_ext;

  always_comb begin
    head_d = head_q + PW'(deq_eff);
    tail_d = tail_q;
    occ_d  = occ_q - deq_eff;
    if (enq_fire) begin
      tail_d = tail_q + PW'(n_cnt);
      occ_d  = occ_q + OW'(n_cnt) - deq_eff;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (bus.flush) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Compacting write: parcel low+k lands at tail+k; storage needs no reset
  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      for (int k = 0; k < PARCELS_PER_FETCH; k++) begin
        if (NW'(k) < n_cnt) begin
          mem_q[tail_q + PW'(k)] <= bus.enq_parcels[low + LW'(k)];
          unc_q[tail_q + PW'(k)] <= bus.enq_parcels[low + LW'(k)][1:0] == 2'b11;
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_win
    ibuffer_parcel_queue_lane #(.IDX(i), .OW(OW)) u_lane (
      .occ_i    (occ_q),
      .parcel_i (mem_q[head_q + PW'(i)]),
      .unc_i    (unc_q[head_q + PW'(i)]),
      .parcel_o (bus.win_parcels[i]),
      .valid_o  (bus.win_valid_vec[i]),
      .unc_o    (bus.win_uncompressed_vec[i])
    );
  end

  a_enq_contig : assert property (@(posedge CLK) disable iff (rst)
    enq_fire |-> mask_contig);
  a_deq_range : assert property (@(posedge CLK) disable iff (rst || bus.flush)
    deq_ext <= occ_q);
endmodule

// File: tb/tb_ibuffer_parcel_queue.sv
// Directed bench for ibuffer_parcel_queue with a queue-based reference model.
module tb_ibuffer_parcel_queue;
  localparam int PPF = 8, DEPTH = 32, W = 8;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  ibuffer_parcel_queue_if #(.PARCELS_PER_FETCH(PPF), .DEPTH(DEPTH), .WIDTH(W)) bus ();
  ibuffer_parcel_queue #(.PARCELS_PER_FETCH(PPF), .DEPTH(DEPTH), .WIDTH(W)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] mq [$];
  logic [PPF-1:0][15:0] p;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    bus.flush         = 1'b0;
    bus.enq_valid     = 1'b0;
    bus.enq_valid_vec = '0;
    bus.enq_parcels   = '0;
    bus.deq_count     = '0;
  endtask

  task automatic check_model(input string tag, input bit win);
    logic [W-1:0] ev, eu;
    logic [W-1:0][15:0] ep;
    chk({tag, ".occ"}, 128'(bus.occupancy), 128'(mq.size()));
    chk({tag, ".rdy"}, 128'(bus.enq_ready), 128'((DEPTH - mq.size()) >= PPF));
    if (win) begin
      for (int i = 0; i < W; i++) begin
        ev[i] = i < mq.size();
        ep[i] = ev[i] ? mq[i] : 16'h0000;
        eu[i] = ev[i] && (ep[i][1:0] == 2'b11);
      end
      chk({tag, ".wvld"}, 128'(bus.win_valid_vec), 128'(ev));
      chk({tag, ".wunc"}, 128'(bus.win_uncompressed_vec), 128'(eu));
      chk({tag, ".wpar"}, 128'(bus.win_parcels), 128'(ep));
    end
  endtask

  // Drive one cycle and advance the reference model in step
  task automatic cyc(input bit ev, input logic [PPF-1:0] m,
                     input logic [PPF-1:0][15:0] pp, input int dq, input bit fl);
    int  sz, d;
    bit  fire;
    sz   = mq.size();
    fire = ev && !fl && ((DEPTH - sz) >= PPF);
    bus.flush         = fl;
    bus.enq_valid     = ev;
    bus.enq_valid_vec = m;
    bus.enq_parcels   = pp;
    bus.deq_count     = 4'(dq);
    tick();
    if (fl) mq.delete();
    else begin
      d = (dq > sz) ? sz : dq;
      repeat (d) void'(mq.pop_front());
      if (fire)
        for (int k = 0; k < PPF; k++)
          if (m[k]) mq.push_back(pp[k]);
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.occ", 128'(bus.occupancy), 128'd0);
    chk("rst.rdy", 128'(bus.enq_ready), 128'd1);
    chk("rst.wvld", 128'(bus.win_valid_vec), 128'h0);
    chk("rst.wunc", 128'(bus.win_uncompressed_vec), 128'h0);
    chk("rst.wpar", 128'(bus.win_parcels), 128'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle.occ", 128'(bus.occupancy), 128'd0);
      chk("idle.rdy", 128'(bus.enq_ready), 128'd1);
      chk("idle.wvld", 128'(bus.win_valid_vec), 128'h0);
    end

    // Full fetch block with mixed compressed / uncompressed parcels
    p[0] = 16'h0001; p[1] = 16'h0003; p[2] = 16'h0000; p[3] = 16'h0002;
    p[4] = 16'h0013; p[5] = 16'h0004; p[6] = 16'h0005; p[7] = 16'h0006;
    cyc(1, 8'hFF, p, 0, 0);
    chk("blk.occ", 128'(bus.occupancy), 128'd8);
    chk("blk.wvld", 128'(bus.win_valid_vec), 128'hFF);
    chk("blk.wunc", 128'(bus.win_uncompressed_vec), 128'h12);
    chk("blk.w1", 128'(bus.win_parcels[1]), 128'h0003);
    chk("blk.w4", 128'(bus.win_parcels[4]), 128'h0013);
    cyc(0, 8'h00, p, 8, 0);
    chk("drain.occ", 128'(bus.occupancy), 128'd0);

    // Upper-half mask is compacted to the head
    for (int k = 0; k < PPF; k++) p[k] = 16'hFFFF;
    p[4] = 16'h1004; p[5] = 16'h1005; p[6] = 16'h1006; p[7] = 16'h1007;
    cyc(1, 8'hF0, p, 0, 0);
    chk("cmp.w0", 128'(bus.win_parcels[0]), 128'h1004);
    chk("cmp.w3", 128'(bus.win_parcels[3]), 128'h1007);
    chk("cmp.w4", 128'(bus.win_parcels[4]), 128'h0000);
    chk("cmp.wvld", 128'(bus.win_valid_vec), 128'h0F);
    chk("cmp.occ", 128'(bus.occupancy), 128'd4);
    cyc(0, 8'h00, p, 4, 0);

    // Full boundary at 25
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < PPF; k++) p[k] = 16'(16'h3000 + j * 8 + k);
      cyc(1, 8'hFF, p, 0, 0);
    end
    p[0] = 16'h30FF;
    cyc(1, 8'h01, p, 0, 0);
    chk("full.occ", 128'(bus.occupancy), 128'd25);
    chk("full.rdy", 128'(bus.enq_ready), 128'd0);
    for (int k = 0; k < PPF; k++) p[k] = 16'(16'h3100 + k);
    cyc(1, 8'hFF, p, 2, 0);
    chk("full.dq.occ", 128'(bus.occupancy), 128'd23);
    chk("full.dq.rdy", 128'(bus.enq_ready), 128'd1);
    for (int k = 0; k < PPF; k++) p[k] = 16'(16'h3200 + k);
    cyc(1, 8'hFF, p, 8, 0);
    chk("full.eqd.occ", 128'(bus.occupancy), 128'd23);
    check_model("full", 1);

    // Pointer wrap with model-checked window every cycle
    cyc(0, 8'h00, p, 0, 1);
    check_model("wrap0", 1);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < PPF; k++) p[k] = 16'(16'h4000 + j * 16 + k * 3);
      cyc(1, 8'hFF, p, 0, 0);
      check_model("wrap.fill", 1);
    end
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < PPF; k++) p[k] = 16'(16'h5000 + j * 16 + k * 7);
      cyc(1, 8'hFF, p, 8, 0);
      check_model("wrap.run", 1);
    end

    // Flush beats same-cycle enqueue and dequeue
    cyc(0, 8'h00, p, 0, 1);
    for (int k = 0; k < PPF; k++) p[k] = 16'(16'h6000 + k);
    cyc(1, 8'hFF, p, 0, 0);
    cyc(1, 8'h0F, p, 0, 0);
    chk("fl.pre.occ", 128'(bus.occupancy), 128'd12);
    cyc(1, 8'hFF, p, 3, 1);
    chk("fl.occ", 128'(bus.occupancy), 128'd0);
    chk("fl.wvld", 128'(bus.win_valid_vec), 128'h0);

    // Reset mid-stream
    cyc(1, 8'hFF, p, 0, 0);
    cyc(1, 8'hFF, p, 0, 0);
    chk("mrst.pre.occ", 128'(bus.occupancy), 128'd16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    chk("mrst.occ", 128'(bus.occupancy), 128'd0);
    chk("mrst.rdy", 128'(bus.enq_ready), 128'd1);
    chk("mrst.wvld", 128'(bus.win_valid_vec), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
